// File: rtl/anc_pkg.sv
// Shared types for the ANC sample aligner: sample width, aligned frame, FSM states.
// Also holds the saturating-counter helpers that the aligner and its counters use.
package anc_pkg;

  localparam int SAMPLE_W = 16;

  typedef struct packed {
    logic signed [SAMPLE_W-1:0] x;
    logic signed [SAMPLE_W-1:0] e;
    logic signed [SAMPLE_W-1:0] a;
  } frame_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_PUSH    = 2'd2
  } state_e;

  function automatic logic [1:0] popcnt3(input logic [2:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
  endfunction

  function automatic logic [7:0] sat_add8(input logic [7:0] v, input logic [1:0] inc);
    logic [8:0] s;
    s = {1'b0, v} + {7'b0, inc};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

endpackage

// File: rtl/anc_frame_fifo.sv
// Sync show-ahead frame FIFO; head visible combinationally, write/read same edge allowed even when full.
// Backpressure: caller only writes when !full or reading, and only reads when !empty.
import anc_pkg::*;

module anc_frame_fifo #(
  parameter int DEPTH = 4
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   wr_vld,
  input  frame_t wr_dat,
  input  logic   rd_rdy,
  output frame_t rd_dat,
  output logic   full,
  output logic   empty
);

  localparam int AW = $clog2(DEPTH);

  frame_t        mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;

  // Extra MSB on each pointer distinguishes full from empty after wrap.
  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_dat = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_vld) wr_ptr <= wr_ptr + 1'b1;
      if (rd_rdy) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_vld) mem[wr_ptr[AW-1:0]] <= wr_dat;
  end

endmodule

// File: rtl/anc_sample_aligner.sv
// Aligns x/e/a channel strobes into frames; 2-cycle strobe-to-in_valid latency, FIFO-full stalls in PUSH.
// Backpressure via controller_ready; skew timeout compiled only with ANC_ALIGN_TIMEOUT_EN.
import anc_pkg::*;

module anc_sample_aligner #(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       init_done,
  input  logic                       x_valid,
  input  logic                       e_valid,
  input  logic                       a_valid,
  input  logic signed [SAMPLE_W-1:0] x_data,
  input  logic signed [SAMPLE_W-1:0] e_data,
  input  logic signed [SAMPLE_W-1:0] a_data,
  input  logic                       controller_ready,
  output logic                       in_valid,
  output logic signed [SAMPLE_W-1:0] x_out,
  output logic signed [SAMPLE_W-1:0] e_out,
  output logic signed [SAMPLE_W-1:0] a_out,
  input  logic                       cnt_clr,
  output logic [7:0]                 ovr_cnt,
  output logic [7:0]                 skew_cnt
);

  state_e     state_q, state_d;
  logic [2:0] full_q, full_d;
  frame_t     hold_q, hold_d;
  logic [2:0] stb;
  logic [2:0] ovr_hits;
  logic       push, pop, fifo_full, fifo_empty, timeout;
  frame_t     head;

  assign stb      = {x_valid, e_valid, a_valid};
  assign in_valid = ~fifo_empty;
  assign pop      = in_valid & controller_ready;
  assign x_out    = fifo_empty ? '0 : head.x;
  assign e_out    = fifo_empty ? '0 : head.e;
  assign a_out    = fifo_empty ? '0 : head.a;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      full_q  <= 3'b000;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      full_q  <= full_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    full_d   = full_q;
    hold_d   = hold_q;
    push     = 1'b0;
    ovr_hits = 3'b000;
    if (!init_done || timeout) begin
      full_d = 3'b000;
    end else begin
      // A same-edge pop frees the slot this push lands in.
      if (state_q == ST_PUSH && (!fifo_full || pop)) begin
        push   = 1'b1;
        full_d = 3'b000;
      end
      ovr_hits = stb & full_q;
      if (stb[2] && !full_q[2]) begin
        hold_d.x  = x_data;
        full_d[2] = 1'b1;
      end
      if (stb[1] && !full_q[1]) begin
        hold_d.e  = e_data;
        full_d[1] = 1'b1;
      end
      if (stb[0] && !full_q[0]) begin
        hold_d.a  = a_data;
        full_d[0] = 1'b1;
      end
    end
    if (&full_d)      state_d = ST_PUSH;
    else if (|full_d) state_d = ST_COLLECT;
    else              state_d = ST_IDLE;
  end

  anc_frame_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_vld (push),
    .wr_dat (hold_q),
    .rd_rdy (pop),
    .rd_dat (head),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (!rst_n || cnt_clr) ovr_cnt <= 8'd0;
    else                   ovr_cnt <= sat_add8(ovr_cnt, popcnt3(ovr_hits));
  end

`ifdef ANC_ALIGN_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT) + 1;

  logic [TW-1:0] timer_q;
  logic          skew_inc;

  // Timer restarts on every entry to COLLECT and only runs while there.
  always_ff @(posedge clk) begin
    if (!rst_n || state_q != ST_COLLECT) timer_q <= '0;
    else                                 timer_q <= timer_q + TW'(1);
  end

  assign timeout  = (state_q == ST_COLLECT) && (timer_q == TW'(TIMEOUT - 1));
  assign skew_inc = init_done & timeout;

  always_ff @(posedge clk) begin
    if (!rst_n || cnt_clr) skew_cnt <= 8'd0;
    else                   skew_cnt <= sat_add8(skew_cnt, {1'b0, skew_inc});
  end
`else
  logic timeout_unused;

  assign timeout_unused = (TIMEOUT > 0);
  assign timeout        = 1'b0;
  assign skew_cnt       = 8'd0;
`endif

endmodule

// File: tb/tb_anc_sample_aligner.sv
// Directed bench for anc_sample_aligner: latency, overrun, backpressure, skew, reset, saturation.
module tb_anc_sample_aligner;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               init_done;
  logic               x_valid, e_valid, a_valid;
  logic signed [15:0] x_data, e_data, a_data;
  logic               controller_ready;
  logic               in_valid;
  logic signed [15:0] x_out, e_out, a_out;
  logic               cnt_clr;
  logic [7:0]         ovr_cnt, skew_cnt;

  int checks   = 0;
  int failures = 0;

  anc_sample_aligner dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .init_done        (init_done),
    .x_valid          (x_valid),
    .e_valid          (e_valid),
    .a_valid          (a_valid),
    .x_data           (x_data),
    .e_data           (e_data),
    .a_data           (a_data),
    .controller_ready (controller_ready),
    .in_valid         (in_valid),
    .x_out            (x_out),
    .e_out            (e_out),
    .a_out            (a_out),
    .cnt_clr          (cnt_clr),
    .ovr_cnt          (ovr_cnt),
    .skew_cnt         (skew_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%04h expected=0x%04h", tag, obs, exp);
    end
  endtask

  task automatic check_frame(input string tag, input logic [15:0] xv, input logic [15:0] ev,
                             input logic [15:0] av);
    check({tag, "_valid"}, {15'b0, in_valid}, 16'h0001);
    check({tag, "_x"}, x_out, xv);
    check({tag, "_e"}, e_out, ev);
    check({tag, "_a"}, a_out, av);
  endtask

  task automatic strobe(input logic [2:0] m, input logic [15:0] xv, input logic [15:0] ev,
                        input logic [15:0] av);
    x_valid = m[2];
    e_valid = m[1];
    a_valid = m[0];
    x_data  = xv;
    e_data  = ev;
    a_data  = av;
    step();
    x_valid = 1'b0;
    e_valid = 1'b0;
    a_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; init_done = 1'b1; cnt_clr = 1'b0; controller_ready = 1'b0;
    x_valid = 1'b0; e_valid = 1'b0; a_valid = 1'b0;
    x_data = '0; e_data = '0; a_data = '0;
    idle(3);
    rst_n = 1'b1;

    check("rst_in_valid", {15'b0, in_valid}, 16'h0000);
    check("rst_x_out", x_out, 16'h0000);
    check("rst_e_out", e_out, 16'h0000);
    check("rst_a_out", a_out, 16'h0000);
    check("rst_ovr", {8'b0, ovr_cnt}, 16'd0);
    check("rst_skew", {8'b0, skew_cnt}, 16'd0);

    // Skewed strobes in cycles 0,3,5: frame visible in cycle 7 only.
    controller_ready = 1'b1;
    strobe(3'b100, 16'h0100, 16'h0, 16'h0);
    idle(2);
    strobe(3'b010, 16'h0, 16'hFF00, 16'h0);
    idle(1);
    strobe(3'b001, 16'h0, 16'h0, 16'h0010);
    check("lat_c6_valid", {15'b0, in_valid}, 16'h0000);
    step();
    check_frame("lat_c7", 16'h0100, 16'hFF00, 16'h0010);
    step();
    check("lat_c8_valid", {15'b0, in_valid}, 16'h0000);

    // Overrun on x keeps the first sample.
    strobe(3'b100, 16'h1111, 16'h0, 16'h0);
    strobe(3'b100, 16'h2222, 16'h0, 16'h0);
    check("ovr_one", {8'b0, ovr_cnt}, 16'd1);
    strobe(3'b011, 16'h0, 16'h3333, 16'h4444);
    check("ovr_push_valid", {15'b0, in_valid}, 16'h0000);
    step();
    check_frame("ovr_frame", 16'h1111, 16'h3333, 16'h4444);
    step();
    check("ovr_drained", {15'b0, in_valid}, 16'h0000);

    // Five frames into a depth-4 FIFO with the controller stalled.
    controller_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      strobe(3'b111, 16'h1000 + 16'(i), 16'h2000 + 16'(i), 16'h3000 + 16'(i));
      step();
    end
    idle(2);
    check_frame("bp_head", 16'h1000, 16'h2000, 16'h3000);
    check("bp_no_ovr", {8'b0, ovr_cnt}, 16'd1);
    controller_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check_frame($sformatf("bp_out%0d", i), 16'h1000 + 16'(i), 16'h2000 + 16'(i),
                  16'h3000 + 16'(i));
      step();
    end
    check("bp_empty", {15'b0, in_valid}, 16'h0000);

    // Partial frame left waiting well past the timeout interval.
    strobe(3'b100, 16'h5555, 16'h0, 16'h0);
    idle(70);
`ifdef ANC_ALIGN_TIMEOUT_EN
    check("skew_cnt", {8'b0, skew_cnt}, 16'd1);
    check("skew_no_valid", {15'b0, in_valid}, 16'h0000);
    strobe(3'b111, 16'h6666, 16'h7777, 16'h8888);
    check("skew_push_valid", {15'b0, in_valid}, 16'h0000);
    step();
    check_frame("skew_frame", 16'h6666, 16'h7777, 16'h8888);
`else
    check("skew_cnt", {8'b0, skew_cnt}, 16'd0);
    check("skew_no_valid", {15'b0, in_valid}, 16'h0000);
    strobe(3'b011, 16'h0, 16'h7777, 16'h8888);
    check("skew_push_valid", {15'b0, in_valid}, 16'h0000);
    step();
    check_frame("skew_frame", 16'h5555, 16'h7777, 16'h8888);
`endif
    step();

    // Reset with two frames queued and x held.
    controller_ready = 1'b0;
    strobe(3'b111, 16'h0A01, 16'h0B01, 16'h0C01);
    step();
    strobe(3'b111, 16'h0A02, 16'h0B02, 16'h0C02);
    step();
    strobe(3'b100, 16'h0BAD, 16'h0, 16'h0);
    check("prerst_valid", {15'b0, in_valid}, 16'h0001);
    check("prerst_ovr", {8'b0, ovr_cnt}, 16'd1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("mrst_valid", {15'b0, in_valid}, 16'h0000);
    check("mrst_x_out", x_out, 16'h0000);
    check("mrst_ovr", {8'b0, ovr_cnt}, 16'd0);
    controller_ready = 1'b1;
    strobe(3'b011, 16'h0, 16'h1234, 16'h5678);
    idle(3);
    check("mrst_partial_valid", {15'b0, in_valid}, 16'h0000);
    strobe(3'b100, 16'h0ACE, 16'h0, 16'h0);
    check("mrst_push_valid", {15'b0, in_valid}, 16'h0000);
    step();
    check_frame("mrst_frame", 16'h0ACE, 16'h1234, 16'h5678);
    step();

    // 300 x strobes: one load then 299 overruns, saturating at 255.
    strobe(3'b100, 16'h0001, 16'h0, 16'h0);
    x_valid = 1'b1;
    idle(10);
    check("sat_ten", {8'b0, ovr_cnt}, 16'd10);
    idle(289);
    check("sat_255", {8'b0, ovr_cnt}, 16'd255);
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    x_valid = 1'b0;
    check("clr_wins", {8'b0, ovr_cnt}, 16'd0);
    strobe(3'b100, 16'h0002, 16'h0, 16'h0);
    check("clr_resume", {8'b0, ovr_cnt}, 16'd1);

    // init_done low ignores strobes and drops the held x.
    init_done = 1'b0;
    strobe(3'b111, 16'h0F0F, 16'h0F0F, 16'h0F0F);
    init_done = 1'b1;
    check("init_no_ovr", {8'b0, ovr_cnt}, 16'd1);
    strobe(3'b011, 16'h0, 16'h4321, 16'h8765);
    idle(3);
    check("init_no_valid", {15'b0, in_valid}, 16'h0000);
    strobe(3'b100, 16'h0777, 16'h0, 16'h0);
    step();
    check_frame("init_frame", 16'h0777, 16'h4321, 16'h8765);
    step();
    check("init_drained", {15'b0, in_valid}, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/anc_sample_aligner.md
ANC_SAMPLE_ALIGNER -- requirements
Module: anc_sample_aligner

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, frame FIFO depth (power of two, 2..16).
REQ-002 SHALL have parameter TIMEOUT, default 64, max cycles a partial frame may wait for its missing channels.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port init_done  input  1  high = accept samples; low = discard all channel inputs.
REQ-006 SHALL have ports x_valid, e_valid, a_valid  input  1 each  single-cycle strobe per channel sample.
REQ-007 SHALL have ports x_data, e_data, a_data  input  16 signed each  reference, error and desired samples.
REQ-008 SHALL have port controller_ready  input  1  downstream controller accepts a frame.
REQ-009 SHALL have port in_valid  output  1  aligned frame available.
REQ-010 SHALL have ports x_out, e_out, a_out  output  16 signed each  aligned frame fields, stable while in_valid=1 and controller_ready=0.
REQ-011 SHALL have port cnt_clr  input  1  synchronous clear of both error counters.
REQ-012 SHALL have ports ovr_cnt, skew_cnt  output  8 each  saturating overrun and skew-timeout counts.

Function
REQ-013 SHALL hold one 16-bit hold register plus full flag per channel; a strobe on an empty channel loads it.
REQ-014 SHALL run FSM IDLE (all flags clear) -> COLLECT (1-2 flags set) -> PUSH (all three set) -> IDLE.
REQ-015 SHALL, in PUSH with FIFO not full, write {x,e,a} to the FIFO and clear all three flags on the same edge.
REQ-016 SHALL, in PUSH with FIFO full, stay in PUSH with hold registers unchanged until a slot frees.
REQ-017 SHALL treat a strobe on a channel whose flag is already set as overrun: sample dropped, ovr_cnt +1.
REQ-018 SHALL give latency 2 cycles: strobe completing a frame in cycle c, FIFO empty -> in_valid=1 in cycle c+2.
REQ-019 SHALL pop one frame per cycle where in_valid=1 and controller_ready=1; output is show-ahead.
REQ-020 SHALL permit push and pop on the same edge, including when the FIFO is full; occupancy unchanged.
REQ-021 SHALL accept simultaneous strobes on any channel subset in one cycle; all three together goes directly to PUSH.
REQ-022 SHALL saturate counters at 255; cnt_clr wins over a same-cycle increment.
REQ-023 SHALL, while init_done=0, ignore strobes, clear hold flags and return to IDLE; FIFO contents still drain.
REQ-024 SHALL preserve frame order; FIFO pointers wrap modulo FIFO_DEPTH.

Reset
REQ-025 SHALL, when rst_n=0 at a clock edge, clear FSM to IDLE, all flags, FIFO pointers, counters, timer; in_valid=0, x_out/e_out/a_out=0.
REQ-026 SHALL discard any partial frame and all FIFO contents on reset mid-operation; first post-reset frame needs three fresh strobes.

Configuration
REQ-027 SHALL compile skew timeout only when ANC_ALIGN_TIMEOUT_EN is defined: timer starts on entry to COLLECT and counts cycles there; on reaching TIMEOUT-1, clear flags, return to IDLE, skew_cnt +1.
REQ-028 SHALL, without ANC_ALIGN_TIMEOUT_EN, wait in COLLECT indefinitely and tie skew_cnt to 0.

Structure
REQ-029 SHALL put SAMPLE_W=16, the frame struct typedef {x,e,a} and the FSM state enum in shared package anc_pkg.
REQ-030 SHALL implement the FIFO as sub-module anc_frame_fifo (sync, show-ahead, full/empty flags).

Verification
REQ-031 SHALL test x=0x0100, e=0xFF00, a=0x0010 strobed in cycles 0,3,5, ready=1 -> in_valid in cycle 7 with those values, single pulse.
REQ-032 SHALL test ready=0 with 5 complete frames at FIFO_DEPTH=4 -> 4 stored, FSM holds 5th in PUSH, raise ready -> 5 frames out in order.
REQ-033 SHALL test x strobed twice (0x1111 then 0x2222) before e/a -> ovr_cnt=1, frame carries x=0x1111.
REQ-034 SHALL test with ANC_ALIGN_TIMEOUT_EN, x only, 64 idle cycles -> skew_cnt=1, FSM IDLE, no in_valid; without macro -> skew_cnt=0, frame completes on late e/a.
REQ-035 SHALL test rst_n=0 for one cycle with 2 frames queued and a partial frame -> in_valid=0 next cycle, counters 0, next frame needs all 3 strobes.
REQ-036 SHALL test 300 overruns -> ovr_cnt=255; cnt_clr coincident with overrun -> 0.
